mips_datapath_alu_muldiv_ctrl: RTL and testbench

Sequencer that sits between the decode/issue stage and `Mips_Datapath_Alu_hilo`, sharing the single HI/LO unit among multiply, divide, move-to and move-from operations. It latches operands, holds them stable for a configurable multicycle budget, and drives the HI/LO unit's `func` only in the commit cycle, so HI/LO is written exactly once per operation. It stalls issue while busy and returns `mfhi`/`mflo` results over a one-cycle response strobe.

---
 rtl/mips_datapath_alu_muldiv_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mips_datapath_alu_muldiv_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_datapath_alu_muldiv_ctrl.sv
// Multicycle sequencer for the shared HI/LO unit.
// Latches an issued mul/div/move operation and holds its operands stable.
// Drives the HI/LO function code only in the commit cycle, so HI/LO is
// written exactly once per operation. Returns mfhi/mflo results on a
// one-cycle response strobe.
// Optional feature: MIPS_DATAPATH_ALU_MULDIV_CTRL_DIV0_TRAP_EN adds the div0
// port. With it, a zero divisor is trapped instead of running the full
// divide latency.
module mips_datapath_alu_muldiv_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned DIV_LAT = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [3:0]        i_req_func,
  input  logic [DATA_W-1:0] i_req_data1,
  input  logic [DATA_W-1:0] i_req_data2,
  input  logic              i_flush,
  output logic [3:0]        o_alu_func,
  output logic [DATA_W-1:0] o_alu_data1,
  output logic [DATA_W-1:0] o_alu_data2,
  input  logic [DATA_W-1:0] i_alu_result,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_data,
  output logic              o_busy
`ifdef MIPS_DATAPATH_ALU_MULDIV_CTRL_DIV0_TRAP_EN
  ,
  output logic              o_div0
`endif
);

  // HI/LO unit function encoding
  localparam logic [3:0] FN_NOP  = 4'd0;
  localparam logic [3:0] FN_MULU = 4'd1;
  localparam logic [3:0] FN_MULS = 4'd2;
  localparam logic [3:0] FN_DIVU = 4'd3;
  localparam logic [3:0] FN_DIVS = 4'd4;
  localparam logic [3:0] FN_MTHI = 4'd5;
  localparam logic [3:0] FN_MTLO = 4'd6;
  localparam logic [3:0] FN_MFHI = 4'd7;
  localparam logic [3:0] FN_MFLO = 4'd8;

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(DIV_LAT - 1);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StMove, StRead} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_next;
  logic [3:0]          r_func;
  logic [DATA_W-1:0]   r_data1;
  logic [DATA_W-1:0]   r_data2;
  logic                w_accept;
  logic                w_is_div;
  logic                w_div0_trap;
  logic                w_commit_en;

  assign o_req_ready = (r_state == StIdle) && !i_flush;
  assign w_accept    = i_req_valid && o_req_ready;
  assign o_busy      = (r_state != StIdle);
  assign o_alu_data1 = r_data1;
  assign o_alu_data2 = r_data2;
  assign o_rsp_data  = i_alu_result;
  assign w_is_div    = (i_req_func == FN_DIVU) || (i_req_func == FN_DIVS);

`ifdef MIPS_DATAPATH_ALU_MULDIV_CTRL_DIV0_TRAP_EN
  logic r_div0;

  assign w_div0_trap = w_is_div && (i_req_data2 == '0);
  // A trapped divide spends its single DIV cycle with the write suppressed
  assign w_commit_en = !r_div0;
  assign o_div0      = r_div0;

  // Divide-by-zero flag: one-cycle pulse following the trapped accept
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div0 <= 1'b0;
    end else begin
      r_div0 <= w_accept && w_div0_trap;
    end
  end
`else
  assign w_div0_trap = 1'b0;
  assign w_commit_en = 1'b1;
`endif

  // State, counter and latched operation registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_func  <= FN_NOP;
      r_data1 <= '0;
      r_data2 <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_func  <= i_req_func;
        r_data1 <= i_req_data1;
        r_data2 <= i_req_data2;
      end
    end
  end

  // Next-state and latency counter
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          if ((i_req_func == FN_MULU) || (i_req_func == FN_MULS)) begin
            w_state_next = StMul;
            w_cnt_next   = MUL_CNT_INIT;
          end else if (w_is_div) begin
            w_state_next = StDiv;
            // Zero count makes a trapped divide leave DIV after one cycle
            w_cnt_next   = w_div0_trap ? '0 : DIV_CNT_INIT;
          end else if ((i_req_func == FN_MTHI) || (i_req_func == FN_MTLO)) begin
            w_state_next = StMove;
          end else if ((i_req_func == FN_MFHI) || (i_req_func == FN_MFLO)) begin
            w_state_next = StRead;
          end
        end
      end
      StMul, StDiv: begin
        if (r_cnt == '0) begin
          w_state_next = StIdle;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      StMove, StRead: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
    // Flush abandons whatever is in flight
    if (i_flush) begin
      w_state_next = StIdle;
      w_cnt_next   = '0;
    end
  end

  // HI/LO function and response strobe; flush masks both
  always_comb begin
    o_alu_func  = FN_NOP;
    o_rsp_valid = 1'b0;
    if (!i_flush) begin
      unique case (r_state)
        StMul, StDiv: begin
          if ((r_cnt == '0) && w_commit_en) begin
            o_alu_func = r_func;
          end
        end
        StMove: begin
          o_alu_func = r_func;
        end
        StRead: begin
          o_alu_func  = r_func;
          o_rsp_valid = 1'b1;
        end
        default: begin
          o_alu_func = FN_NOP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_datapath_alu_muldiv_ctrl.sv
// Directed bench for mips_datapath_alu_muldiv_ctrl.
// A behavioural HI/LO unit stands in for the real one. Inputs are driven and
// outputs sampled on the falling clock edge.
module tb_mips_datapath_alu_muldiv_ctrl;

  localparam logic [3:0] FN_NOP  = 4'd0;
  localparam logic [3:0] FN_MULU = 4'd1;
  localparam logic [3:0] FN_MULS = 4'd2;
  localparam logic [3:0] FN_DIVU = 4'd3;
  localparam logic [3:0] FN_DIVS = 4'd4;
  localparam logic [3:0] FN_MTHI = 4'd5;
  localparam logic [3:0] FN_MTLO = 4'd6;
  localparam logic [3:0] FN_MFHI = 4'd7;
  localparam logic [3:0] FN_MFLO = 4'd8;
  localparam logic [3:0] FN_ADD  = 4'd9;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_func;
  logic [31:0] req_data1;
  logic [31:0] req_data2;
  logic        flush;
  logic [3:0]  alu_func;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;
`ifdef MIPS_DATAPATH_ALU_MULDIV_CTRL_DIV0_TRAP_EN
  logic        div0;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  mips_datapath_alu_muldiv_ctrl #(
    .DATA_W  (32),
    .MUL_LAT (4),
    .DIV_LAT (32)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_func   (req_func),
    .i_req_data1  (req_data1),
    .i_req_data2  (req_data2),
    .i_flush      (flush),
    .o_alu_func   (alu_func),
    .o_alu_data1  (alu_data1),
    .o_alu_data2  (alu_data2),
    .i_alu_result (alu_result),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_data   (rsp_data),
    .o_busy       (busy)
`ifdef MIPS_DATAPATH_ALU_MULDIV_CTRL_DIV0_TRAP_EN
    ,
    .o_div0       (div0)
`endif
  );

  // Behavioural HI/LO unit; a zero-divisor write leaves a visible signature
  logic [31:0] hi;
  logic [31:0] lo;

  function automatic logic [63:0] smul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] x;
    logic signed [63:0] y;
    x = {{32{a[31]}}, a};
    y = {{32{b[31]}}, b};
    return x * y;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else begin
      case (alu_func)
        FN_MULU: {hi, lo} <= {32'd0, alu_data1} * {32'd0, alu_data2};
        FN_MULS: {hi, lo} <= smul(alu_data1, alu_data2);
        FN_DIVU: begin
          if (alu_data2 == 0) begin hi <= alu_data1; lo <= '1; end
          else begin lo <= alu_data1 / alu_data2; hi <= alu_data1 % alu_data2; end
        end
        FN_DIVS: begin
          if (alu_data2 == 0) begin hi <= alu_data1; lo <= '1; end
          else begin
            lo <= $signed(alu_data1) / $signed(alu_data2);
            hi <= $signed(alu_data1) % $signed(alu_data2);
          end
        end
        FN_MTHI: hi <= alu_data1;
        FN_MTLO: lo <= alu_data1;
        default: ;
      endcase
    end
  end

  assign alu_result = (alu_func == FN_MFHI) ? hi : (alu_func == FN_MFLO) ? lo : 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request, wait for acceptance, return in the cycle after accept
  task automatic issue(input logic [3:0] f, input logic [31:0] d1, input logic [31:0] d2);
    int unsigned n = 0;
    @(negedge clk);
    req_valid = 1'b1;
    req_func  = f;
    req_data1 = d1;
    req_data2 = d2;
    #1;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!req_ready) check("issue_timeout", 0, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_func  = FN_NOP;
    #1;
  endtask

  task automatic read_hilo(input logic [3:0] f, input logic [31:0] exp, input string tag);
    issue(f, 32'd0, 32'd0);
    check({tag, "_vld"}, rsp_valid, 1);
    check(tag, rsp_data, exp);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_func  = FN_NOP;
    req_data1 = '0;
    req_data2 = '0;
    flush     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_ready", req_ready, 1);
    check("rst_func", alu_func, FN_NOP);
    check("rst_rsp", rsp_valid, 0);
    check("rst_data1", alu_data1, 0);
    check("rst_data2", alu_data2, 0);

    // Move to HI, then read it back
    issue(FN_MTHI, 32'h1234_5678, 32'h0);
    check("mthi_func", alu_func, FN_MTHI);
    check("mthi_ready", req_ready, 0);
    check("mthi_data1", alu_data1, 32'h1234_5678);
    @(negedge clk); #1;
    check("mthi_ready_back", req_ready, 1);
    check("mthi_busy_back", busy, 0);
    read_hilo(FN_MFHI, 32'h1234_5678, "mfhi1");
    check("mfhi1_ready", req_ready, 0);
    @(negedge clk); #1;
    check("mfhi1_rsp_one_cycle", rsp_valid, 0);
    check("mfhi1_ready_back", req_ready, 1);

    // Unsigned multiply: three Nop cycles, then commit
    issue(FN_MULU, 32'h0001_0000, 32'h0001_0000);
    for (int i = 0; i < 3; i++) begin
      check("mul_nop", alu_func, FN_NOP);
      @(negedge clk); #1;
    end
    check("mul_commit", alu_func, FN_MULU);
    check("mul_busy", busy, 1);
    @(negedge clk); #1;
    check("mul_ready_back", req_ready, 1);
    read_hilo(FN_MFHI, 32'h1, "mulu_hi");
    read_hilo(FN_MFLO, 32'h0, "mulu_lo");

    // Signed multiply
    issue(FN_MULS, 32'hFFFF_FFFD, 32'd5);
    read_hilo(FN_MFHI, 32'hFFFF_FFFF, "muls_hi");
    read_hilo(FN_MFLO, 32'hFFFF_FFF1, "muls_lo");

    // Unrecognised function is accepted and dropped
    issue(FN_ADD, 32'd1, 32'd2);
    check("add_busy", busy, 0);
    check("add_ready", req_ready, 1);
    check("add_latched", alu_data1, 32'd1);

    // Signed divide: busy for the whole divide latency
    issue(FN_DIVS, 32'hFFFF_FFF9, 32'd2);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk); #1;
    end
    check("divs_busy_cycles", cnt, 32);
    read_hilo(FN_MFLO, 32'hFFFF_FFFD, "divs_lo");
    read_hilo(FN_MFHI, 32'hFFFF_FFFF, "divs_hi");

    // Flush on the commit cycle suppresses the write
    issue(FN_DIVU, 32'd100, 32'd7);
    repeat (31) @(negedge clk);
    #1;
    check("divu_commit_func", alu_func, FN_DIVU);
    flush = 1'b1;
    #1;
    check("flush_func", alu_func, FN_NOP);
    check("flush_ready", req_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_ready_back", req_ready, 1);
    check("flush_busy", busy, 0);
    read_hilo(FN_MFHI, 32'hFFFF_FFFF, "flush_hi");
    read_hilo(FN_MFLO, 32'hFFFF_FFFD, "flush_lo");

    // Flush coincident with a request blocks the accept
    @(negedge clk);
    flush     = 1'b1;
    req_valid = 1'b1;
    req_func  = FN_MTLO;
    req_data1 = 32'hDEAD_BEEF;
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    req_func  = FN_NOP;
    #1;
    check("flush_accept_busy", busy, 0);
    read_hilo(FN_MFLO, 32'hFFFF_FFFD, "flush_accept_lo");

    // Reset in the second cycle of a multiply abandons it
    issue(FN_MULU, 32'd3, 32'd5);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_busy", busy, 0);
    check("rstmid_func", alu_func, FN_NOP);
    check("rstmid_ready", req_ready, 1);
    repeat (5) @(negedge clk);
    read_hilo(FN_MFLO, 32'h0, "rstmid_lo");

`ifdef MIPS_DATAPATH_ALU_MULDIV_CTRL_DIV0_TRAP_EN
    issue(FN_DIVU, 32'd9, 32'd0);
    check("div0_flag", div0, 1);
    check("div0_func", alu_func, FN_NOP);
    check("div0_busy", busy, 1);
    @(negedge clk); #1;
    check("div0_flag_clear", div0, 0);
    check("div0_ready", req_ready, 1);
    read_hilo(FN_MFHI, 32'h0, "div0_hi");
    read_hilo(FN_MFLO, 32'h0, "div0_lo");
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
